// File: rtl/sdram_to_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_to_uart_fifo
//  Description : Queues SDRAM read-data / write-done report requests and
//                serializes each one as a byte message for a UART
//                transmitter. Read reports send the sampled word MSB-first;
//                write reports send "OK"; an optional terminator byte can
//                follow every message.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_to_uart_fifo #(
    parameter int         SD_W      = 16,
    parameter int         DEPTH     = 4,
    parameter int         TERM_EN   = 0,
    parameter logic [7:0] TERM_BYTE = 8'h0A
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic [7:0]               o_data,
    output logic                     o_stb,
    input  logic                     o_ack,
    input  logic [SD_W-1:0]          sd_data,
    input  logic                     i_stb_rd,
    input  logic                     i_stb_wt,
    output logic                     i_ack,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_NB = SD_W / 8;
    // Byte index must also reach 1 for the two-byte write report
    localparam int c_IW = (c_NB > 2) ? $clog2(c_NB) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_TERM = 2'd2;

    // FIFO entry: {is_read, word}
    logic [SD_W:0]       r_mem [DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW:0]       r_level;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_IW-1:0]     r_idx;
    logic                r_cur_rd;
    logic [SD_W-1:0]     r_cur_word;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_last;
    logic [SD_W-1:0]     w_shifted;
    logic [7:0]          w_rd_byte;

    assign w_full  = (r_level == (c_AW+1)'(DEPTH));
    // Acceptance is independent of a same-cycle pop, and forced low in reset
    assign i_ack   = (i_stb_rd | i_stb_wt) & ~w_full & ~RST;
    assign w_push  = i_ack;
    assign w_pop   = (r_state == c_IDLE) && (r_level != '0);
    assign o_level = r_level;

    // Last byte of the current message: word bytes for reads, two for writes
    assign w_last    = r_cur_rd ? (r_idx == c_IW'(c_NB - 1)) : (r_idx == c_IW'(1));
    // Shift the selected byte up to the top of the word (MSB-first order)
    assign w_shifted = r_cur_word << {r_idx, 3'b000};
    assign w_rd_byte = w_shifted[SD_W-1 -: 8];

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_stb_rd, sd_data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_AW+1)'(1);
                2'b01:   r_level <= r_level - (c_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Load the head entry on pop and step the byte index on each accepted byte
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cur_rd   <= 1'b0;
            r_cur_word <= '0;
            r_idx      <= '0;
        end else if (w_pop) begin
            {r_cur_rd, r_cur_word} <= r_mem[r_rd_ptr];
            r_idx                  <= '0;
        end else if ((r_state == c_SEND) && o_ack && !w_last) begin
            r_idx <= r_idx + c_IW'(1);
        end
    end

    // Serializer state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Serializer next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_level != '0) begin
                    w_state_nxt = c_SEND;
                end
            end
            c_SEND: begin
                if (o_ack && w_last) begin
                    w_state_nxt = (TERM_EN != 0) ? c_TERM : c_IDLE;
                end
            end
            c_TERM: begin
                if (o_ack) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Serializer outputs: byte strobe and byte value per state
    always_comb begin
        o_stb  = 1'b0;
        o_data = 8'h00;
        case (r_state)
            c_SEND: begin
                o_stb  = 1'b1;
                if (r_cur_rd) begin
                    o_data = w_rd_byte;
                end else begin
                    o_data = (r_idx == '0) ? 8'h4F : 8'h4B;
                end
            end
            c_TERM: begin
                o_stb  = 1'b1;
                o_data = TERM_BYTE;
            end
            default: begin
                o_stb  = 1'b0;
                o_data = 8'h00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_to_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_to_uart_fifo
//  Description : Two DUT instances (16-bit/depth 4/no terminator and
//                32-bit/depth 2/terminator) share stimulus; each is compared
//                every cycle with a message-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_to_uart_fifo;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rd  = 1'b0;
    logic        wt  = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] d   = '0;

    logic [7:0]  a_data, b_data;
    logic        a_stb, b_stb, a_iack, b_iack;
    logic [2:0]  a_level;
    logic [1:0]  b_level;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    sdram_to_uart_fifo #(.SD_W(16), .DEPTH(4), .TERM_EN(0), .TERM_BYTE(8'h0A)) dut_a (
        .CLK(CLK), .RST(RST), .o_data(a_data), .o_stb(a_stb), .o_ack(ack),
        .sd_data(d[15:0]), .i_stb_rd(rd), .i_stb_wt(wt), .i_ack(a_iack), .o_level(a_level)
    );

    sdram_to_uart_fifo #(.SD_W(32), .DEPTH(2), .TERM_EN(1), .TERM_BYTE(8'h0A)) dut_b (
        .CLK(CLK), .RST(RST), .o_data(b_data), .o_stb(b_stb), .o_ack(ack),
        .sd_data(d), .i_stb_rd(rd), .i_stb_wt(wt), .i_ack(b_iack), .o_level(b_level)
    );

    // Reference model: per instance a queue of pending requests (ring) and
    // the byte list of the message currently being sent.
    logic [32:0] mf  [2][8];
    int          mh  [2];
    int          mc  [2];
    logic [7:0]  mb  [2][8];
    int          mbn [2];
    int          mbi [2];
    logic        a_iack_s;

    function automatic int m_sdw(input int i);   return (i == 0) ? 16 : 32; endfunction
    function automatic int m_depth(input int i); return (i == 0) ? 4 : 2;   endfunction
    function automatic bit m_term(input int i);  return (i == 1);           endfunction

    function automatic bit exp_ack(input int i);
        return (rd || wt) && (mc[i] < m_depth(i)) && !RST;
    endfunction

    function automatic bit exp_stb(input int i);
        return mbi[i] < mbn[i];
    endfunction

    function automatic logic [7:0] exp_data(input int i);
        return (mbi[i] < mbn[i]) ? mb[i][mbi[i]] : 8'h00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mh[i] = 0; mc[i] = 0; mbn[i] = 0; mbi[i] = 0;
        end
    endtask

    // Turn a request into its byte message
    task automatic expand(input int i, input logic [32:0] e);
        logic [31:0] w;
        int n;
        n = 0;
        if (e[32]) begin
            for (int k = 0; k < m_sdw(i) / 8; k++) begin
                w = e[31:0] >> (m_sdw(i) - 8 - 8 * k);
                mb[i][n] = w[7:0];
                n = n + 1;
            end
        end else begin
            mb[i][0] = 8'h4F;
            mb[i][1] = 8'h4B;
            n = 2;
        end
        if (m_term(i)) begin
            mb[i][n] = 8'h0A;
            n = n + 1;
        end
        mbn[i] = n;
        mbi[i] = 0;
    endtask

    // Advance the model across one rising edge using the held inputs
    task automatic model_edge(input bit ea0, input bit ea1);
        bit ea;
        logic [31:0] dd;
        for (int i = 0; i < 2; i++) begin
            ea = (i == 0) ? ea0 : ea1;
            if (mbi[i] < mbn[i]) begin
                if (ack) mbi[i] = mbi[i] + 1;
            end else if (mc[i] > 0) begin
                expand(i, mf[i][mh[i]]);
                mh[i] = (mh[i] + 1) % 8;
                mc[i] = mc[i] - 1;
            end
            if (ea) begin
                dd = (i == 0) ? {16'h0000, d[15:0]} : d;
                mf[i][(mh[i] + mc[i]) % 8] = {rd, dd};
                mc[i] = mc[i] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outs();
        chk("A i_ack",  a_iack,  exp_ack(0));
        chk("A o_stb",  a_stb,   exp_stb(0));
        chk("A o_data", a_data,  exp_data(0));
        chk("A level",  a_level, mc[0]);
        chk("B i_ack",  b_iack,  exp_ack(1));
        chk("B o_stb",  b_stb,   exp_stb(1));
        chk("B o_data", b_data,  exp_data(1));
        chk("B level",  b_level, mc[1]);
    endtask

    task automatic check_reset_outs();
        chk("rst A o_stb",  a_stb,   0);
        chk("rst A o_data", a_data,  0);
        chk("rst A i_ack",  a_iack,  0);
        chk("rst A level",  a_level, 0);
        chk("rst B o_stb",  b_stb,   0);
        chk("rst B o_data", b_data,  0);
        chk("rst B i_ack",  b_iack,  0);
        chk("rst B level",  b_level, 0);
    endtask

    // One clock cycle: drive just after an edge, check mid-cycle, step model
    task automatic cyc(input bit r, input bit w, input bit a, input logic [31:0] dv);
        bit ea0, ea1;
        rd = r; wt = w; ack = a; d = dv;
        #2;
        check_outs();
        a_iack_s = a_iack;
        ea0 = exp_ack(0);
        ea1 = exp_ack(1);
        @(posedge CLK);
        model_edge(ea0, ea1);
        #1;
    endtask

    // Assert reset between edges and confirm outputs clear before any edge
    task automatic do_reset_mid();
        rd = 1'b1; wt = 1'b1; ack = 1'b1;
        #1;
        RST = 1'b1;
        #1;
        check_reset_outs();
        model_clear();
        @(posedge CLK);
        #1;
        rd = 1'b0; wt = 1'b0; ack = 1'b0;
        RST = 1'b0;
    endtask

    initial begin
        int k;
        int acc;
        bit rd_done, wt_done;
        model_clear();

        // Reset state with requests pending: nothing accepted, nothing sent
        rd = 1'b1; wt = 1'b1; ack = 1'b1; d = 32'h1234_5678;
        #3;
        check_reset_outs();
        @(posedge CLK);
        #1;
        rd = 1'b0; wt = 1'b0; RST = 1'b0;

        // Single read, o_ack tied high
        cyc(1, 0, 1, 32'h0000_A55A);
        repeat (8) cyc(0, 0, 1, 32'h0);

        // Six held reads against a stalled transmitter, then release
        k = 1; acc = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(k <= 6, 0, c >= 8, {16'h0000, k[7:0], k[7:0]});
            if (c < 8 && a_iack_s) acc = acc + 1;
            if (a_iack_s) k = k + 1;
        end
        chk("A accepted while stalled", acc, 5);
        repeat (4) cyc(0, 0, 1, 32'h0);

        // Both strobes together: read first, held write follows
        rd_done = 0; wt_done = 0;
        for (int c = 0; c < 16; c++) begin
            cyc(!rd_done, !wt_done, 1, 32'h0000_1234);
            if (a_iack_s) begin
                if (!rd_done) rd_done = 1;
                else          wt_done = 1;
            end
        end

        // Wide word with o_ack every third cycle
        for (int c = 0; c < 24; c++) begin
            cyc(c == 0, 0, (c % 3) == 2, 32'hDEAD_BEEF);
        end

        // Reset mid-message with a second entry queued
        cyc(1, 0, 0, 32'h1111_1111);
        cyc(1, 0, 0, 32'h2222_2222);
        cyc(0, 0, 0, 32'h0);
        cyc(0, 0, 1, 32'h0);
        do_reset_mid();
        repeat (6) cyc(0, 0, 1, 32'h0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset_mid();
            end else begin
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 2) != 0, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
